stage3: RTL and testbench
=========================

Name: stage3

Overview:
- Third pipeline stage of the pipelined square-root datapath. Sits directly downstream of the Stage2 register bank.
- Resolves the split high/low partial results that Stage2 registers:
  - completes the 12-bit high remainder add with the low-part carry;
  - completes the 4-bit high root increment with the root carry;
  - registers the merged 17-bit remainder, 8-bit root, the quotient decision bit and a valid flag for the next stage.
- Adds a valid qualifier, a synchronous flush and a sticky root-overflow error flag.

Parameters:
- REM_HI_W, 12, width of A_high/B_high and of the high remainder field.
- REM_LO_W, 5, width of the low remainder field (square_sum).
- ROOT_HI_W, 4, width of the high root field.
- ROOT_LO_W, 4, width of the low root field (root_sum).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en_pipe_i  in  1  pipeline advance enable, shared with all stages.
- flush_i  in  1  synchronous flush; kills in-flight valid.
- S3_valid_i  in  1  Stage2 outputs hold a real operand.
- S3_N_i  in  1  from S2_N_o.
- S3_square_sum_i  in  5  from S2_square_sum_o.
- S3_Co_square_i  in  1  from S2_Co_square_o.
- S3_A_high_i  in  12  from S2_A_high_o.
- S3_B_high_i  in  12  from S2_B_high_o.
- S3_root_sum_i  in  4  from S2_root_sum_o.
- S3_Co_root_i  in  1  from S2_Co_root_o.
- S3_root_high_i  in  4  from S2_root_high_o.
- S3_valid_o  out  1  registered valid.
- S3_N_o  out  1  registered pass-through of N.
- S3_rem_o  out  17  registered remainder {high_sum, square_sum}.
- S3_rem_neg_o  out  1  registered: remainder negative (no carry out of high add).
- S3_q_bit_o  out  1  registered quotient bit = ~rem_neg.
- S3_root_o  out  8  registered root {root_high_res, root_sum}.
- S3_root_ovf_o  out  1  sticky root-increment overflow error.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low. On assertion, every output register clears to 0 immediately, independent of clk, including S3_valid_o and S3_root_ovf_o.
- Combinational resolve (computed from the inputs):
  - {cy, hs[11:0]} = S3_A_high_i + S3_B_high_i + S3_Co_square_i, computed 13 bits wide.
  - rem = {hs, S3_square_sum_i}.
  - neg = ~cy.
  - rh[3:0] = S3_root_high_i + S3_Co_root_i, mod 16.
  - ovf_now = (S3_root_high_i==4'hF) & S3_Co_root_i.
- Latency: 1 cycle. Outputs reflect the inputs sampled at the rising edge where en_pipe_i=1.
- Per rising edge, after reset is released, priority is:
  1. flush_i=1: S3_valid_o <= 0. Data registers update as normal when en_pipe_i=1 and hold otherwise. Flush works regardless of en_pipe_i.
  2. en_pipe_i=1 (no flush): all data registers load. S3_valid_o <= S3_valid_i.
  3. en_pipe_i=0 (no flush): every register holds, including valid (stall).
- Sticky overflow: set when a load occurs with S3_valid_i=1 and ovf_now=1. Cleared only by rst_n. An invalid operand never sets it, nor does a flushed one.
- Data registers load regardless of S3_valid_i, so bubbles carry don't-care data. Consumers must qualify with S3_valid_o.
- Simultaneous flush_i=1 and en_pipe_i=1 with S3_valid_i=1: valid_o=0, overflow is not set, and data loads.
- rst_n deasserted mid-stall: registers stay 0 until the first en_pipe_i=1 edge.
- Internal state elements reuse the team's set/reset/enable register cells, with the set input tied inactive.

Optional Feature:
- Macro: STAGE3_RESULT_COUNT_EN.
- Defined:
  - Adds output S3_res_cnt_o [15:0], which counts edges where a valid result is loaded (en_pipe_i=1, S3_valid_i=1, flush_i=0).
  - Wraps 16'hFFFF -> 0. Asynchronously cleared by rst_n.
- Undefined:
  - The port and counter are absent. All other behaviour is identical.

Test Plan:
- Reset: rst_n=0 mid-cycle with outputs non-zero -> all outputs 0 immediately, without waiting for a clk edge.
- Resolve: A_high=12'h800, B_high=12'h7FF, Co_square=1, square_sum=5'h15, root_high=4'h3, Co_root=1, root_sum=4'hA, valid=1, en=1 -> next cycle rem=17'h00015, rem_neg=0, q_bit=1, root=8'h4A, valid_o=1.
- Negative remainder: A_high=12'h000, B_high=12'hFFE, Co_square=0 -> rem[16:5]=12'hFFE, rem_neg=1, q_bit=0.
- Stall: load one operand, then hold en_pipe_i=0 for 3 cycles while the inputs change -> outputs unchanged for all 3 cycles.
- Flush: en=1, flush=1, valid_i=1, root_high=4'hF, Co_root=1 -> valid_o=0, root=8'h0X, root_ovf stays 0. Repeat without flush -> root_ovf=1 and stays 1 after the inputs go benign, until rst_n=0.
- STAGE3_RESULT_COUNT_EN: 5 valid loads, 2 bubbles and 1 flushed load -> S3_res_cnt_o=5. Preload 16'hFFFF then 1 valid load -> 0.

Source files
------------

// File: rtl/stage3.sv
// Square-root pipeline stage 3: merges Stage2's split remainder/root partials and registers them.
// Optional macro STAGE3_RESULT_COUNT_EN adds a 16-bit counter of accepted valid results.

module stage3_srff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         set_i,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] q_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else if (set_i) begin
      q_q <= '1;
    end else if (en_i) begin
      q_q <= d_i;
    end
  end

  assign q_o = q_q;

endmodule

module stage3 #(
  parameter int REM_HI_W  = 12,
  parameter int REM_LO_W  = 5,
  parameter int ROOT_HI_W = 4,
  parameter int ROOT_LO_W = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en_pipe_i,
  input  logic                          flush_i,
  input  logic                          S3_valid_i,
  input  logic                          S3_N_i,
  input  logic [REM_LO_W-1:0]           S3_square_sum_i,
  input  logic                          S3_Co_square_i,
  input  logic [REM_HI_W-1:0]           S3_A_high_i,
  input  logic [REM_HI_W-1:0]           S3_B_high_i,
  input  logic [ROOT_LO_W-1:0]          S3_root_sum_i,
  input  logic                          S3_Co_root_i,
  input  logic [ROOT_HI_W-1:0]          S3_root_high_i,
  output logic                          S3_valid_o,
  output logic                          S3_N_o,
  output logic [REM_HI_W+REM_LO_W-1:0]  S3_rem_o,
  output logic                          S3_rem_neg_o,
  output logic                          S3_q_bit_o,
  output logic [ROOT_HI_W+ROOT_LO_W-1:0] S3_root_o,
  output logic                          S3_root_ovf_o
`ifdef STAGE3_RESULT_COUNT_EN
  ,
  output logic [15:0]                   S3_res_cnt_o
`endif
);

  localparam int REM_W  = REM_HI_W + REM_LO_W;
  localparam int ROOT_W = ROOT_HI_W + ROOT_LO_W;

  // High remainder add with the low-part carry folded in; MSB of the result is the carry out.
  function automatic logic [REM_HI_W:0] hi_add(input logic [REM_HI_W-1:0] a,
                                               input logic [REM_HI_W-1:0] b,
                                               input logic                cin);
    return {1'b0, a} + {1'b0, b} + {{REM_HI_W{1'b0}}, cin};
  endfunction

  function automatic logic [ROOT_HI_W-1:0] root_inc(input logic [ROOT_HI_W-1:0] rh,
                                                    input logic                 cin);
    return rh + {{(ROOT_HI_W-1){1'b0}}, cin};
  endfunction

  logic [REM_HI_W:0]   hi_sum;
  logic [REM_W-1:0]    rem_d;
  logic                neg_d;
  logic [ROOT_W-1:0]   root_d;
  logic                ovf_now;
  logic                accept;
  logic                valid_en;
  logic                valid_d;
  logic                ovf_en;

  always_comb begin
    hi_sum   = hi_add(S3_A_high_i, S3_B_high_i, S3_Co_square_i);
    rem_d    = {hi_sum[REM_HI_W-1:0], S3_square_sum_i};
    neg_d    = ~hi_sum[REM_HI_W];
    root_d   = {root_inc(S3_root_high_i, S3_Co_root_i), S3_root_sum_i};
    ovf_now  = (S3_root_high_i == {ROOT_HI_W{1'b1}}) & S3_Co_root_i;
    accept   = en_pipe_i & S3_valid_i & ~flush_i;
    // Flush clears valid even while stalled; otherwise valid only moves with the pipe.
    valid_en = en_pipe_i | flush_i;
    valid_d  = S3_valid_i & ~flush_i;
    ovf_en   = accept & ovf_now;
  end

  // ---- Stage3 register boundary ----
  logic                valid_q;
  logic                n_q;
  logic [REM_W-1:0]    rem_q;
  logic                neg_q;
  logic                qbit_q;
  logic [ROOT_W-1:0]   root_q;
  logic                ovf_q;

  stage3_srff #(.W(1)) u_valid (
    .clk(clk), .rst_n(rst_n), .set_i(1'b0), .en_i(valid_en), .d_i(valid_d), .q_o(valid_q)
  );

  stage3_srff #(.W(1)) u_n (
    .clk(clk), .rst_n(rst_n), .set_i(1'b0), .en_i(en_pipe_i), .d_i(S3_N_i), .q_o(n_q)
  );

  stage3_srff #(.W(REM_W)) u_rem (
    .clk(clk), .rst_n(rst_n), .set_i(1'b0), .en_i(en_pipe_i), .d_i(rem_d), .q_o(rem_q)
  );

  stage3_srff #(.W(1)) u_neg (
    .clk(clk), .rst_n(rst_n), .set_i(1'b0), .en_i(en_pipe_i), .d_i(neg_d), .q_o(neg_q)
  );

  stage3_srff #(.W(1)) u_qbit (
    .clk(clk), .rst_n(rst_n), .set_i(1'b0), .en_i(en_pipe_i), .d_i(~neg_d), .q_o(qbit_q)
  );

  stage3_srff #(.W(ROOT_W)) u_root (
    .clk(clk), .rst_n(rst_n), .set_i(1'b0), .en_i(en_pipe_i), .d_i(root_d), .q_o(root_q)
  );

  // Sticky: only ever loads a 1, so nothing but rst_n can clear it.
  stage3_srff #(.W(1)) u_ovf (
    .clk(clk), .rst_n(rst_n), .set_i(1'b0), .en_i(ovf_en), .d_i(1'b1), .q_o(ovf_q)
  );

  assign S3_valid_o    = valid_q;
  assign S3_N_o        = n_q;
  assign S3_rem_o      = rem_q;
  assign S3_rem_neg_o  = neg_q;
  assign S3_q_bit_o    = qbit_q;
  assign S3_root_o     = root_q;
  assign S3_root_ovf_o = ovf_q;

`ifdef STAGE3_RESULT_COUNT_EN
  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  assign cnt_d = cnt_q + 16'd1;

  stage3_srff #(.W(16)) u_cnt (
    .clk(clk), .rst_n(rst_n), .set_i(1'b0), .en_i(accept), .d_i(cnt_d), .q_o(cnt_q)
  );

  assign S3_res_cnt_o = cnt_q;
`endif

endmodule

// File: tb/tb_stage3.sv
// Directed bench for stage3: arithmetic reference model checked every cycle plus literal pins.
// With STAGE3_RESULT_COUNT_EN defined it also exercises the result counter and its wrap.

module tb_stage3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en_pipe_i, flush_i, S3_valid_i, S3_N_i, S3_Co_square_i, S3_Co_root_i;
  logic [4:0]  S3_square_sum_i;
  logic [11:0] S3_A_high_i, S3_B_high_i;
  logic [3:0]  S3_root_sum_i, S3_root_high_i;
  logic        S3_valid_o, S3_N_o, S3_rem_neg_o, S3_q_bit_o, S3_root_ovf_o;
  logic [16:0] S3_rem_o;
  logic [7:0]  S3_root_o;
`ifdef STAGE3_RESULT_COUNT_EN
  logic [15:0] S3_res_cnt_o;
`endif

  stage3 dut (
    .clk(clk), .rst_n(rst_n), .en_pipe_i(en_pipe_i), .flush_i(flush_i),
    .S3_valid_i(S3_valid_i), .S3_N_i(S3_N_i), .S3_square_sum_i(S3_square_sum_i),
    .S3_Co_square_i(S3_Co_square_i), .S3_A_high_i(S3_A_high_i), .S3_B_high_i(S3_B_high_i),
    .S3_root_sum_i(S3_root_sum_i), .S3_Co_root_i(S3_Co_root_i), .S3_root_high_i(S3_root_high_i),
    .S3_valid_o(S3_valid_o), .S3_N_o(S3_N_o), .S3_rem_o(S3_rem_o), .S3_rem_neg_o(S3_rem_neg_o),
    .S3_q_bit_o(S3_q_bit_o), .S3_root_o(S3_root_o), .S3_root_ovf_o(S3_root_ovf_o)
`ifdef STAGE3_RESULT_COUNT_EN
    , .S3_res_cnt_o(S3_res_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit started = 1'b0;

  // Reference state derived from plain integer arithmetic.
  int m_valid, m_n, m_rem, m_neg, m_q, m_root, m_ovf, m_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_n = 0; m_rem = 0; m_neg = 0; m_q = 0; m_root = 0; m_ovf = 0; m_cnt = 0;
  endtask

  task automatic model_edge();
    int sum, rsum;
    if (rst_n !== 1'b1) return;
    if (flush_i) m_valid = 0;
    if (en_pipe_i) begin
      sum    = int'(S3_A_high_i) + int'(S3_B_high_i) + int'(S3_Co_square_i);
      rsum   = int'(S3_root_high_i) + int'(S3_Co_root_i);
      m_rem  = (sum % 4096) * 32 + int'(S3_square_sum_i);
      m_neg  = (sum < 4096) ? 1 : 0;
      m_q    = 1 - m_neg;
      m_root = (rsum % 16) * 16 + int'(S3_root_sum_i);
      m_n    = int'(S3_N_i);
      if (!flush_i) begin
        m_valid = int'(S3_valid_i);
        if (S3_valid_i) begin
          m_cnt = (m_cnt + 1) % 65536;
          if (rsum > 15) m_ovf = 1;
        end
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic n, input logic [11:0] ah, input logic [11:0] bh,
                       input logic cs, input logic [4:0] ss, input logic [3:0] rh,
                       input logic cr, input logic [3:0] rs, input logic en, input logic fl);
    S3_valid_i = v; S3_N_i = n; S3_A_high_i = ah; S3_B_high_i = bh; S3_Co_square_i = cs;
    S3_square_sum_i = ss; S3_root_high_i = rh; S3_Co_root_i = cr; S3_root_sum_i = rs;
    en_pipe_i = en; flush_i = fl;
  endtask

  always @(negedge clk) begin
    if (started) begin
      chk("valid", 32'(S3_valid_o), 32'(m_valid));
      chk("N", 32'(S3_N_o), 32'(m_n));
      chk("rem", 32'(S3_rem_o), 32'(m_rem));
      chk("rem_neg", 32'(S3_rem_neg_o), 32'(m_neg));
      chk("q_bit", 32'(S3_q_bit_o), 32'(m_q));
      chk("root", 32'(S3_root_o), 32'(m_root));
      chk("root_ovf", 32'(S3_root_ovf_o), 32'(m_ovf));
`ifdef STAGE3_RESULT_COUNT_EN
      chk("res_cnt", 32'(S3_res_cnt_o), 32'(m_cnt));
`endif
    end
  end

  initial begin
    rst_n = 1'b0;
    model_reset();
    drive(0, 0, 12'h0, 12'h0, 0, 5'h0, 4'h0, 0, 4'h0, 0, 0);
    @(negedge clk);
    started = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    chk("reset_valid", 32'(S3_valid_o), 32'd0);
    chk("reset_root_ovf", 32'(S3_root_ovf_o), 32'd0);

    // Resolve with carry rippling through the whole high field.
    drive(1, 1, 12'h800, 12'h7FF, 1, 5'h15, 4'h3, 1, 4'hA, 1, 0);
    cyc();
    chk("resolve_rem", 32'(S3_rem_o), 32'h00015);
    chk("resolve_neg", 32'(S3_rem_neg_o), 32'd0);
    chk("resolve_q", 32'(S3_q_bit_o), 32'd1);
    chk("resolve_root", 32'(S3_root_o), 32'h4A);
    chk("resolve_valid", 32'(S3_valid_o), 32'd1);

    // Negative remainder: no carry out of the high add.
    drive(1, 0, 12'h000, 12'hFFE, 0, 5'h03, 4'h7, 0, 4'h2, 1, 0);
    cyc();
    chk("neg_rem_hi", 32'(S3_rem_o[16:5]), 32'hFFE);
    chk("neg_flag", 32'(S3_rem_neg_o), 32'd1);
    chk("neg_q", 32'(S3_q_bit_o), 32'd0);

    // Stall: load, then hold for 3 cycles while inputs wander.
    drive(1, 1, 12'h123, 12'h456, 1, 5'h0A, 4'h5, 0, 4'h6, 1, 0);
    cyc();
    for (int i = 0; i < 3; i++) begin
      drive(i[0], 0, 12'hFFF - 12'(i), 12'h00F, 1, 5'h1F, 4'hF, 1, 4'hF, 0, 0);
      cyc();
      chk("stall_rem", 32'(S3_rem_o), 32'h0AF4A);
      chk("stall_root", 32'(S3_root_o), 32'h56);
      chk("stall_valid", 32'(S3_valid_o), 32'd1);
    end
    // Flush during a stall kills valid but holds data.
    drive(1, 0, 12'h001, 12'h001, 0, 5'h01, 4'h1, 0, 4'h1, 0, 1);
    cyc();
    chk("stall_flush_valid", 32'(S3_valid_o), 32'd0);
    chk("stall_flush_rem", 32'(S3_rem_o), 32'h0AF4A);

    // Flushed overflowing operand: data loads, no valid, no overflow.
    drive(1, 0, 12'h010, 12'h020, 0, 5'h04, 4'hF, 1, 4'h5, 1, 1);
    cyc();
    chk("flush_valid", 32'(S3_valid_o), 32'd0);
    chk("flush_root_hi", 32'(S3_root_o[7:4]), 32'h0);
    chk("flush_ovf", 32'(S3_root_ovf_o), 32'd0);
    // Invalid overflowing operand must not set the sticky flag.
    drive(0, 0, 12'h010, 12'h020, 0, 5'h04, 4'hF, 1, 4'h5, 1, 0);
    cyc();
    chk("bubble_ovf", 32'(S3_root_ovf_o), 32'd0);
    // Valid overflowing operand sets it, and it stays set.
    drive(1, 0, 12'h010, 12'h020, 0, 5'h04, 4'hF, 1, 4'h5, 1, 0);
    cyc();
    chk("ovf_set", 32'(S3_root_ovf_o), 32'd1);
    drive(1, 1, 12'h100, 12'h200, 0, 5'h02, 4'h2, 0, 4'h3, 1, 0);
    repeat (3) cyc();
    chk("ovf_sticky", 32'(S3_root_ovf_o), 32'd1);

    // Asynchronous reset mid-cycle with non-zero outputs.
    drive(1, 1, 12'h100, 12'h200, 0, 5'h02, 4'h2, 0, 4'h3, 0, 0);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("areset_valid", 32'(S3_valid_o), 32'd0);
    chk("areset_rem", 32'(S3_rem_o), 32'd0);
    chk("areset_root", 32'(S3_root_o), 32'd0);
    chk("areset_ovf", 32'(S3_root_ovf_o), 32'd0);
    chk("areset_n", 32'(S3_N_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) cyc();
    chk("post_reset_stall_rem", 32'(S3_rem_o), 32'd0);
    chk("post_reset_stall_valid", 32'(S3_valid_o), 32'd0);

    // 5 valid loads, 2 bubbles, 1 flushed load.
    for (int i = 0; i < 8; i++) begin
      drive((i != 2 && i != 5) ? 1'b1 : 1'b0, i[0], 12'(i * 300), 12'(4000 - i * 77), i[1],
            5'(i * 3), 4'(i + 9), i[0], 4'(i), 1, (i == 7) ? 1'b1 : 1'b0);
      cyc();
    end
    chk("last_flushed_valid", 32'(S3_valid_o), 32'd0);
`ifdef STAGE3_RESULT_COUNT_EN
    chk("cnt_five", 32'(S3_res_cnt_o), 32'd5);
    drive(1, 0, 12'h001, 12'h002, 0, 5'h00, 4'h1, 0, 4'h0, 1, 0);
    for (int i = 0; i < 65530; i++) cyc();
    chk("cnt_full", 32'(S3_res_cnt_o), 32'hFFFF);
    cyc();
    chk("cnt_wrap", 32'(S3_res_cnt_o), 32'd0);
`endif

    drive(0, 0, 12'h0, 12'h0, 0, 5'h0, 4'h0, 0, 4'h0, 0, 0);
    cyc();
    started = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
